irq_ctrl: RTL and testbench

//  Interrupt controller between the bus devices (TC timers and peripherals) and CP0.

---
 rtl/irq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches device IRQ lines into pending bits, masks them and
// holds one prioritised request to CP0 until software acknowledges it with an EOI write.
module irq_ctrl #(
  parameter logic [31:0] BASE  = 32'h0000_7F40,
  parameter int          N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             we,
  input  logic [31:0]      wd,
  output logic [31:0]      RD,
  input  logic [N_SRC-1:0] src_irq,
  output logic             irq_out,
  output logic [2:0]       irq_id
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [N_SRC-1:0] pend_q, pend_d, mask_q, mask_d, prev_q, prev_d;
  logic [N_SRC-1:0] set_s, clr_s, elig_s;
  logic             gen_q, gen_d, edge_q, edge_d;
  state_t           state_q, state_d;
  logic             irq_out_q, irq_out_d;
  logic [2:0]       irq_id_q, irq_id_d, sel_s;
  logic [31:0]      off_s;
  logic             in_win_s, wr_pend_s, wr_mask_s, wr_ctrl_s, wr_stat_s;
  logic             eoi_ok_s, withdraw_s;
  logic [7:0]       clr8_s, pend8_s, mask8_s;
  logic             unused_s;

  function automatic logic [7:0] ext8(input logic [N_SRC-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    r[N_SRC-1:0] = v;
    return r;
  endfunction

  assign unused_s = ^wd;

  // Address decode relative to the register window
  always_comb begin
    off_s     = Addr - BASE;
    in_win_s  = (off_s[31:4] == 28'h0);
    wr_pend_s = we & in_win_s & (off_s[3:0] == 4'h0);
    wr_mask_s = we & in_win_s & (off_s[3:0] == 4'h4);
    wr_ctrl_s = we & in_win_s & (off_s[3:0] == 4'h8);
    wr_stat_s = we & in_win_s & (off_s[3:0] == 4'hC);
  end

  always_comb begin
    RD = 32'h0;
    if (in_win_s) begin
      case (off_s[3:0])
        4'h0:    RD = {24'h0, ext8(pend_q)};
        4'h4:    RD = {24'h0, ext8(mask_q)};
        4'h8:    RD = {30'h0, edge_q, gen_q};
        4'hC:    RD = {irq_out_q, 28'h0, irq_id_q};
        default: RD = 32'h0;
      endcase
    end else begin
      RD = 32'h0;
    end
  end

  // Pending/mask/control next state; a same-cycle set overrides any clear
  always_comb begin
    eoi_ok_s = wr_stat_s & (state_q == ACTIVE) & (wd[2:0] == irq_id_q);
    set_s    = edge_q ? (src_irq & ~prev_q) : src_irq;
    clr8_s   = 8'h00;
    if (wr_pend_s) begin
      clr8_s = ext8(wd[N_SRC-1:0]);
    end else begin
      clr8_s = 8'h00;
    end
    if (eoi_ok_s) begin
      clr8_s = clr8_s | (8'h01 << irq_id_q);
    end else begin
      clr8_s = clr8_s;
    end
    clr_s  = clr8_s[N_SRC-1:0];
    pend_d = (pend_q & ~clr_s) | set_s;
    prev_d = src_irq;
    mask_d = wr_mask_s ? wd[N_SRC-1:0] : mask_q;
    gen_d  = wr_ctrl_s ? wd[0] : gen_q;
    edge_d = wr_ctrl_s ? wd[1] : edge_q;
  end

  // Priority pick: lowest eligible index wins
  always_comb begin
    elig_s = pend_q & mask_q & {N_SRC{gen_q}};
    sel_s  = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig_s[i]) begin
        sel_s = 3'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Withdraw looks at the values taking effect this edge so it drops with the write
  always_comb begin
    pend8_s    = ext8(pend_d);
    mask8_s    = ext8(mask_d);
    withdraw_s = ~pend8_s[irq_id_q] | ~mask8_s[irq_id_q] | ~gen_d;
    state_d    = state_q;
    irq_out_d  = irq_out_q;
    irq_id_d   = irq_id_q;
    case (state_q)
      IDLE: begin
        if (|elig_s) begin
          state_d   = ACTIVE;
          irq_out_d = 1'b1;
          irq_id_d  = sel_s;
        end else begin
          irq_out_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (eoi_ok_s || withdraw_s) begin
          state_d   = IDLE;
          irq_out_d = 1'b0;
        end else begin
          irq_out_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        irq_out_d = 1'b0;
      end
    endcase
  end

  // All state, including the request FSM, with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      mask_q    <= '0;
      prev_q    <= '0;
      gen_q     <= 1'b0;
      edge_q    <= 1'b0;
      state_q   <= IDLE;
      irq_out_q <= 1'b0;
      irq_id_q  <= 3'd0;
    end else begin
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      prev_q    <= prev_d;
      gen_q     <= gen_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      irq_out_q <= irq_out_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations queued as stimulus is applied,
// popped and compared against register reads and the request outputs.
module tb_irq_ctrl;
  localparam logic [31:0] BASE = 32'h0000_7F40;
  localparam int N_SRC = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] Addr = 32'h0;
  logic we = 1'b0;
  logic [31:0] wd = 32'h0;
  logic [31:0] RD;
  logic [N_SRC-1:0] src_irq = '0;
  logic irq_out;
  logic [2:0] irq_id;

  irq_ctrl #(.BASE(BASE), .N_SRC(N_SRC)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .we(we), .wd(wd), .RD(RD),
    .src_irq(src_irq), .irq_out(irq_out), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic observe(input logic [31:0] obs);
    sb_t it;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected nothing", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    Addr = BASE + off;
    wd   = data;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    wd   = 32'h0;
    Addr = BASE + 32'h40;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
    expect_q(tag, exp);
    Addr = BASE + off;
    #1;
    observe(RD);
    Addr = BASE + 32'h40;
  endtask

  task automatic check_irq(input string tag, input logic o, input logic [2:0] id);
    expect_q(tag, {28'h0, o, id});
    observe({28'h0, irq_out, irq_id});
  endtask

  task automatic check_out(input string tag, input logic o);
    expect_q(tag, {31'h0, o});
    observe({31'h0, irq_out});
  endtask

  initial begin
    // Reset state
    tick();
    reset = 1'b0;
    tick();
    check_reg("rst_pend", 32'h0, 32'h0);
    check_reg("rst_mask", 32'h4, 32'h0);
    check_reg("rst_ctrl", 32'h8, 32'h0);
    check_reg("rst_stat", 32'hC, 32'h0);

    // 1: edge pulse on source 2
    bus_write(32'h4, 32'h3F);
    bus_write(32'h8, 32'h3);
    check_reg("ctrl_rb", 32'h8, 32'h3);
    src_irq = 6'h04;
    tick();
    src_irq = 6'h00;
    check_reg("t1_pend", 32'h0, 32'h04);
    check_out("t1_not_yet", 1'b0);
    tick();
    check_irq("t1_issue", 1'b1, 3'd2);
    check_reg("t1_stat", 32'hC, 32'h8000_0002);
    bus_write(32'hC, 32'h2);
    check_out("t1_eoi", 1'b0);
    check_reg("t1_pend_clr", 32'h0, 32'h0);

    // 2: priority between sources 4 and 1, gap after EOI
    src_irq = 6'h12;
    tick();
    src_irq = 6'h00;
    check_reg("t2_pend", 32'h0, 32'h12);
    tick();
    check_irq("t2_id1", 1'b1, 3'd1);
    bus_write(32'hC, 32'h1);
    check_out("t2_gap", 1'b0);
    tick();
    check_irq("t2_id4", 1'b1, 3'd4);
    bus_write(32'hC, 32'h4);
    check_out("t2_done", 1'b0);
    check_reg("t2_pend0", 32'h0, 32'h0);

    // 3: mismatched EOI ignored, then withdraw by masking
    src_irq = 6'h08;
    tick();
    src_irq = 6'h00;
    tick();
    check_irq("t3_id3", 1'b1, 3'd3);
    bus_write(32'hC, 32'h5);
    check_irq("t3_bad_eoi", 1'b1, 3'd3);
    check_reg("t3_pend_kept", 32'h0, 32'h08);
    bus_write(32'h4, 32'h37);
    check_out("t3_withdraw", 1'b0);
    check_reg("t3_pend3", 32'h0, 32'h08);
    bus_write(32'h0, 32'h08);
    check_reg("t3_w1c", 32'h0, 32'h0);
    bus_write(32'h4, 32'h3F);

    // 4: level mode re-pends while the line stays high
    bus_write(32'h8, 32'h1);
    src_irq = 6'h01;
    tick();
    check_reg("t4_pend", 32'h0, 32'h01);
    tick();
    check_irq("t4_id0", 1'b1, 3'd0);
    bus_write(32'hC, 32'h0);
    check_out("t4_gap", 1'b0);
    check_reg("t4_repend", 32'h0, 32'h01);
    tick();
    check_irq("t4_reissue", 1'b1, 3'd0);
    src_irq = 6'h00;
    bus_write(32'hC, 32'h0);
    check_out("t4_quiet", 1'b0);
    check_reg("t4_pend0", 32'h0, 32'h0);

    // 5: W1C alone clears, W1C racing an edge leaves the bit set
    bus_write(32'h8, 32'h3);
    bus_write(32'h4, 32'h00);
    src_irq = 6'h01;
    tick();
    src_irq = 6'h00;
    check_reg("t5_pend", 32'h0, 32'h01);
    bus_write(32'h0, 32'h01);
    check_reg("t5_w1c", 32'h0, 32'h0);
    src_irq = 6'h01;
    bus_write(32'h0, 32'h01);
    src_irq = 6'h00;
    check_reg("t5_set_wins", 32'h0, 32'h01);
    check_out("t5_masked", 1'b0);

    // 6: asynchronous reset while ACTIVE
    bus_write(32'h4, 32'h3F);
    tick();
    check_irq("t6_active", 1'b1, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    check_out("t6_async_drop", 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_reg("t6_pend", 32'h0, 32'h0);
    check_reg("t6_mask", 32'h4, 32'h0);
    check_reg("t6_ctrl", 32'h8, 32'h0);
    check_reg("t6_stat", 32'hC, 32'h0);

    // Unmapped offsets: writes ignored, reads zero
    bus_write(32'h14, 32'hFF);
    check_reg("unmapped_wr", 32'h4, 32'h0);
    bus_write(32'h4, 32'h3F);
    check_reg("unaligned_rd", 32'h5, 32'h0);
    check_reg("mask_rb", 32'h4, 32'h3F);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
